// File: rtl/plc_check_scheduler.sv
// plc_check_scheduler: queues PLC check reads and slots them onto the shared cache read port.
//
// Optional feature macro: PLC_SCHED_STARVE_EN (forced issue after MAX_WAIT blocked cycles).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   chk_req/chk_addr/chk_way  check request push (accepted when chk_ready)
//   chk_ready                 FIFO not full
//   read_enable_in, addr_in, way_in, alt_mx_sel_in       core read request
//   read_enable_out, addr_out, way_out, alt_mx_sel_out   registered array read port
//   core_stall                registered, core must hold its request
//   chk_data_valid, chk_ret_addr, chk_ret_way            returning check data tag
//   chk_overflow              sticky, push arrived while full
module plc_check_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int WAY_WIDTH  = 4,
    parameter int DEPTH      = 4,
    parameter int MAX_WAIT   = 16,
    parameter int READ_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chk_req,
    input  logic [ADDR_WIDTH-1:0] chk_addr,
    input  logic [WAY_WIDTH-1:0]  chk_way,
    output logic                  chk_ready,
    input  logic                  read_enable_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [WAY_WIDTH-1:0]  way_in,
    input  logic                  alt_mx_sel_in,
    output logic                  read_enable_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [WAY_WIDTH-1:0]  way_out,
    output logic                  alt_mx_sel_out,
    output logic                  core_stall,
    output logic                  chk_data_valid,
    output logic [ADDR_WIDTH-1:0] chk_ret_addr,
    output logic [WAY_WIDTH-1:0]  chk_ret_way,
    output logic                  chk_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, PENDING, FORCE} state_t;

    state_t                              state, state_nxt;
    logic   [ADDR_WIDTH-1:0]             addr_mem [DEPTH];
    logic   [WAY_WIDTH-1:0]              way_mem  [DEPTH];
    logic   [PW-1:0]                     wr_ptr, rd_ptr;
    logic   [CW-1:0]                     count;
    logic                                push, pop, iss_q;
    logic   [READ_LAT-1:0]               ret_valid;
    logic   [READ_LAT-1:0][ADDR_WIDTH-1:0] ret_addr;
    logic   [READ_LAT-1:0][WAY_WIDTH-1:0]  ret_way;

    assign chk_ready = count != CW'(DEPTH);
    assign push      = chk_req && chk_ready;

`ifdef PLC_SCHED_STARVE_EN
    localparam int WC = $clog2(MAX_WAIT) + 1;
    logic [WC-1:0] wait_cnt;

    // Counts consecutive cycles the head check lost the port to the core.
    always_ff @(posedge clk) begin
        if (rst || pop || state == IDLE)
            wait_cnt <= '0;
        else if (state == PENDING && read_enable_in && wait_cnt != WC'(MAX_WAIT))
            wait_cnt <= wait_cnt + WC'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            core_stall <= 1'b0;
        else
            core_stall <= state_nxt == FORCE;
    end
`else
    assign core_stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (push) state_nxt = PENDING;
            PENDING: begin
                if (pop && !push && count == CW'(1)) state_nxt = IDLE;
`ifdef PLC_SCHED_STARVE_EN
                if (read_enable_in && wait_cnt == WC'(MAX_WAIT - 1)) state_nxt = FORCE;
`endif
            end
            FORCE: state_nxt = (!push && count == CW'(1)) ? IDLE : PENDING;
            default: state_nxt = IDLE;
        endcase
    end

    // FORCE always issues: the core is holding its request under the stall.
    always_comb begin
        pop = (state == PENDING && !read_enable_in) || state == FORCE;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= chk_addr;
            way_mem[wr_ptr]  <= chk_way;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            chk_overflow    <= 1'b0;
            iss_q           <= 1'b0;
            read_enable_out <= 1'b0;
            addr_out        <= '0;
            way_out         <= '0;
            alt_mx_sel_out  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count           <= count + CW'(push) - CW'(pop);
            chk_overflow    <= chk_overflow | (chk_req & ~chk_ready);
            iss_q           <= pop;
            read_enable_out <= pop | read_enable_in;
            if (pop) begin
                addr_out       <= addr_mem[rd_ptr];
                way_out        <= way_mem[rd_ptr];
                alt_mx_sel_out <= 1'b1;
            end else if (read_enable_in) begin
                addr_out       <= addr_in;
                way_out        <= way_in;
                alt_mx_sel_out <= alt_mx_sel_in;
            end
        end
    end

    // Stage 0 captures the read visible on the port; the tail lines up with array data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_valid <= '0;
            ret_addr  <= '0;
            ret_way   <= '0;
        end else begin
            ret_valid[0] <= iss_q;
            ret_addr[0]  <= addr_out;
            ret_way[0]   <= way_out;
            for (int i = 1; i < READ_LAT; i++) begin
                ret_valid[i] <= ret_valid[i-1];
                ret_addr[i]  <= ret_addr[i-1];
                ret_way[i]   <= ret_way[i-1];
            end
        end
    end

    assign chk_data_valid = ret_valid[READ_LAT-1];
    assign chk_ret_addr   = ret_addr[READ_LAT-1];
    assign chk_ret_way    = ret_way[READ_LAT-1];
endmodule

// File: tb/tb_plc_check_scheduler.sv
// tb_plc_check_scheduler: directed and random stimulus against a queue-based reference model.
module tb_plc_check_scheduler;
    localparam int AW = 8;
    localparam int WW = 4;
    localparam int DEPTH = 4;
    localparam int MAX_WAIT = 16;
    localparam int READ_LAT = 2;
`ifdef PLC_SCHED_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          chk_req = 1'b0;
    logic [AW-1:0] chk_addr = '0;
    logic [WW-1:0] chk_way = '0;
    logic          chk_ready;
    logic          read_enable_in = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [WW-1:0] way_in = '0;
    logic          alt_mx_sel_in = 1'b0;
    logic          read_enable_out, alt_mx_sel_out, core_stall, chk_data_valid, chk_overflow;
    logic [AW-1:0] addr_out, chk_ret_addr;
    logic [WW-1:0] way_out, chk_ret_way;

    always #5 clk = ~clk;

    plc_check_scheduler #(
        .ADDR_WIDTH(AW), .WAY_WIDTH(WW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .rst(rst), .chk_req(chk_req), .chk_addr(chk_addr), .chk_way(chk_way),
        .chk_ready(chk_ready), .read_enable_in(read_enable_in), .addr_in(addr_in),
        .way_in(way_in), .alt_mx_sel_in(alt_mx_sel_in), .read_enable_out(read_enable_out),
        .addr_out(addr_out), .way_out(way_out), .alt_mx_sel_out(alt_mx_sel_out),
        .core_stall(core_stall), .chk_data_valid(chk_data_valid), .chk_ret_addr(chk_ret_addr),
        .chk_ret_way(chk_ret_way), .chk_overflow(chk_overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending checks as a queue, returns as an issue history.
    logic [AW+WW-1:0] q[$];
    int               w = 0;
    logic             m_stall = 1'b0, m_re = 1'b0, m_alt = 1'b0, m_ovf = 1'b0;
    logic [AW-1:0]    m_addr = '0;
    logic [WW-1:0]    m_way = '0;
    logic [AW+WW:0]   hist [READ_LAT+1];
    int               stall_seen = 0;

    initial foreach (hist[k]) hist[k] = '0;

    task automatic step();
        bit issue, blocked, do_push, nxt_stall;
        logic [AW+WW-1:0] h;
        @(posedge clk);
        h = '0;
        issue = 1'b0;
        if (rst) begin
            q.delete();
            w = 0;
            {m_stall, m_re, m_alt, m_ovf, m_addr, m_way} = '0;
            foreach (hist[k]) hist[k] = '0;
        end else begin
            do_push = chk_req && q.size() < DEPTH;
            if (chk_req && q.size() == DEPTH) m_ovf = 1'b1;
            issue = q.size() > 0 && (!read_enable_in || m_stall);
            blocked = q.size() > 0 && !issue;
            nxt_stall = STARVE && blocked && w == MAX_WAIT - 1;
            w = (issue || q.size() == 0) ? 0 : w + 1;
            if (issue) begin
                h = q.pop_front();
                m_re = 1'b1;
                {m_addr, m_way} = h;
                m_alt = 1'b1;
            end else if (read_enable_in) begin
                m_re = 1'b1;
                m_addr = addr_in;
                m_way = way_in;
                m_alt = alt_mx_sel_in;
            end else
                m_re = 1'b0;
            if (do_push) q.push_back({chk_addr, chk_way});
            m_stall = nxt_stall;
            for (int k = READ_LAT; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {issue, h};
        end
        #1;
        check("chk_ready", chk_ready, q.size() < DEPTH);
        check("read_enable_out", read_enable_out, m_re);
        check("addr_out", addr_out, m_addr);
        check("way_out", way_out, m_way);
        check("alt_mx_sel_out", alt_mx_sel_out, m_alt);
        check("core_stall", core_stall, m_stall);
        check("chk_overflow", chk_overflow, m_ovf);
        check("chk_data_valid", chk_data_valid, hist[READ_LAT][AW+WW]);
        if (hist[READ_LAT][AW+WW]) begin
            check("chk_ret_addr", chk_ret_addr, hist[READ_LAT][AW+WW-1:WW]);
            check("chk_ret_way", chk_ret_way, hist[READ_LAT][WW-1:0]);
        end
        if (core_stall) stall_seen++;
    endtask

    task automatic drive(input logic r, input logic req, input logic [AW-1:0] ca, input logic [WW-1:0] cw,
                         input logic re, input logic [AW-1:0] a);
        rst = r;
        chk_req = req;
        chk_addr = ca;
        chk_way = cw;
        read_enable_in = re;
        addr_in = a;
        way_in = 4'h3;
        alt_mx_sel_in = 1'b0;
        step();
    endtask

    initial begin
        logic [AW-1:0] fill [5];
        fill = '{8'h34, 8'hAA, 8'h55, 8'hEE, 8'hDD};
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        // single check through an idle core
        drive(0, 1, 8'h12, 4'hC, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("first_issue_addr", addr_out, 32'h12);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        // fill past full while the core owns the port, then drain
        for (int i = 0; i < 5; i++) drive(0, 1, fill[i], 4'(i), 1, 8'h40);
        check("full_overflow", chk_overflow, 1);
        repeat (6) drive(0, 0, 0, 0, 0, 0);
        // starvation: one check behind a continuous core read
        drive(0, 1, 8'h55, 4'h5, 1, 8'h77);
        stall_seen = 0;
        repeat (MAX_WAIT + 4) drive(0, 0, 0, 0, 1, 8'h77);
        check("stall_cycles", stall_seen, STARVE ? 1 : 0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        // push and pop in the same cycle with two queued
        drive(0, 1, 8'hA1, 4'h1, 1, 8'h10);
        drive(0, 1, 8'hA2, 4'h2, 1, 8'h11);
        drive(0, 1, 8'hA3, 4'h3, 0, 0);
        check("same_cycle_count", chk_ready, 1);
        repeat (5) drive(0, 0, 0, 0, 0, 0);
        // reset with two checks in flight
        drive(0, 1, 8'hB1, 4'h1, 0, 0);
        drive(0, 1, 8'hB2, 4'h2, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("reset_flush_re", read_enable_out, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0);
        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++)
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 4, AW'($urandom),
                  WW'($urandom), $urandom_range(0, 9) < 7, AW'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/plc_check_scheduler.md
# plc_check_scheduler

Sequencer that owns the cache read port on behalf of the PLC checker. It queues pending (address, way) check requests, issues each as a check read on the shared port when the core leaves a free slot, and forces a slot by stalling the core if a check waits too long. It also reports which line's data is on the read bus after the fixed array latency, so the PLC compare logic can sample it. The block sits between the core's read request signals and the cache array read port, alongside `plc_wrapper`.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, cache index width
- `WAY_WIDTH`, 4, way-select width
- `DEPTH`, 4, check FIFO entries (power of 2, ≥2)
- `MAX_WAIT`, 16, blocked cycles before forced issue (≥2)
- `READ_LAT`, 2, cycles from issue to valid array data (≥1)

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high; one clock, all state sampled on rising edge.
- `chk_req` in 1: push a check request.
- `chk_addr` in ADDR_WIDTH: request address.
- `chk_way` in WAY_WIDTH: request way.
- `chk_ready` out 1: FIFO not full (combinational from count).
- `read_enable_in` in 1: core read request.
- `addr_in` in ADDR_WIDTH: core address.
- `way_in` in WAY_WIDTH: core way.
- `alt_mx_sel_in` in 1: core alt-mux select.
- `read_enable_out` out 1: registered, to array.
- `addr_out` out ADDR_WIDTH: registered, to array.
- `way_out` out WAY_WIDTH: registered, to array.
- `alt_mx_sel_out` out 1: registered, to array.
- `core_stall` out 1: registered; core must hold its request.
- `chk_data_valid` out 1: one-cycle pulse; array data belongs to a check.
- `chk_ret_addr` out ADDR_WIDTH: address of returning check.
- `chk_ret_way` out WAY_WIDTH: way of returning check.
- `chk_overflow` out 1: sticky; a push arrived while the FIFO was full.

## Operation
- FIFO holds {addr, way}.
  - Push when `chk_req && chk_ready`. A push while full is dropped and sets `chk_overflow`.
  - Push and pop in the same cycle are legal and leave the count unchanged.
  - No bypass: a pushed entry can issue no earlier than the following cycle.
- States:
  - IDLE: FIFO empty.
  - PENDING: FIFO non-empty.
  - FORCE: stall asserted, forced issue pending.
- IDLE → PENDING on push. PENDING → IDLE when the last entry pops with no push.
- PENDING behaviour:
  - If `read_enable_in`=0: issue the head (pop).
  - Else: pass the core request through and increment `wait_cnt`.
  - `wait_cnt` == MAX_WAIT-1 while blocked → FORCE.
- FORCE: `core_stall`=1 for exactly one cycle. The next cycle issues the head regardless of `read_enable_in`, drops the core request (core is holding it), and returns to PENDING or IDLE.
- `wait_cnt` clears on every issue and in IDLE.
- Issue drives `read_enable_out`=1, `addr_out`/`way_out`=head, and `alt_mx_sel_out`=1.
- Pass-through copies the core signals verbatim. With no core read and no issue, `read_enable_out`=0 and the other outputs hold their last value.
- Return tracking: a READ_LAT-deep shift pipe of {valid, addr, way} records each issue. Its output drives `chk_data_valid`, `chk_ret_addr` and `chk_ret_way`.
- Counters saturate, never wrap. `wait_cnt` is $clog2(MAX_WAIT)+1 bits. Count is $clog2(DEPTH)+1 bits.

## Timing
- Reset values:
  - All outputs 0; `chk_ready`=1.
  - FIFO empty, pointers 0, `wait_cnt` 0, state IDLE, return pipe cleared.
  - `chk_overflow` clears only on reset.
- Array outputs reflect inputs sampled at edge N on the outputs after edge N. Latency 1 cycle, for both pass-through and issue.
- `chk_data_valid` rises exactly READ_LAT cycles after the cycle in which the check's `read_enable_out` is high.
- `core_stall` rises the cycle after `wait_cnt` reaches MAX_WAIT-1. The forced issue appears on the next cycle's outputs.
- Back-to-back idle core cycles issue one check per cycle.
- Reset mid-operation flushes queued and in-flight checks; no `chk_data_valid` pulse follows reset.

## Configuration
- `PLC_SCHED_STARVE_EN`
  - Defined: FORCE state and `wait_cnt` are present, as above.
  - Undefined: checks issue only in idle slots, `core_stall` is tied 0, `wait_cnt` is removed, and PENDING never leaves on a blocked count.

## Test plan
- Reset, push {0x12, 0xC} with `read_enable_in`=0 → next-cycle outputs `read_enable_out`=1, `addr_out`=0x12, `way_out`=0xC, `alt_mx_sel_out`=1. `chk_data_valid` pulses 2 cycles later with `chk_ret_addr`=0x12.
- Push 4 entries (0x34, 0xAA, 0x55, 0xEE) with core reading, then a 5th (0xDD) → `chk_ready`=0 and `chk_overflow`=1. Once the core idles, the 4 issue in FIFO order on consecutive cycles.
- Core read 0x77 continuous with one queued check (0x55), STARVE_EN defined → 16 pass-through cycles, `core_stall` high 1 cycle, then `addr_out`=0x55 with `alt_mx_sel_out`=1, then `wait_cnt`=0.
- Same stimulus with macro undefined → `core_stall` stays 0. 0x55 issues only on the first cycle with `read_enable_in`=0.
- Push and pop in the same cycle with 2 entries queued → count stays 2, order preserved.
- Assert `rst` while 2 checks are in flight → outputs 0 next cycle, no `chk_data_valid` pulse afterwards, `chk_ready`=1.
